// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared ISA constants, ID/EX stage record and forwarding helper
//               for the 16-bit processor.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam int DATA_W = 16;
    localparam int REG_AW = 4;
    localparam int OP_W   = 4;
    localparam int IMM_W  = 8;

    localparam logic [OP_W-1:0] OP_ADD    = 4'b0000;
    localparam logic [OP_W-1:0] OP_SUB    = 4'b0001;
    localparam logic [OP_W-1:0] OP_XOR    = 4'b0010;
    localparam logic [OP_W-1:0] OP_RED    = 4'b0011;
    localparam logic [OP_W-1:0] OP_SLL    = 4'b0100;
    localparam logic [OP_W-1:0] OP_SRA    = 4'b0101;
    localparam logic [OP_W-1:0] OP_ROR    = 4'b0110;
    localparam logic [OP_W-1:0] OP_PADDSB = 4'b0111;
    localparam logic [OP_W-1:0] OP_LW     = 4'b1000;
    localparam logic [OP_W-1:0] OP_SW     = 4'b1001;
    localparam logic [OP_W-1:0] OP_LLB    = 4'b1010;
    localparam logic [OP_W-1:0] OP_LHB    = 4'b1011;
    localparam logic [OP_W-1:0] OP_B      = 4'b1100;
    localparam logic [OP_W-1:0] OP_BR     = 4'b1101;
    localparam logic [OP_W-1:0] OP_PCS    = 4'b1110;
    localparam logic [OP_W-1:0] OP_HLT    = 4'b1111;

    typedef struct packed {
        logic              valid;
        logic [OP_W-1:0]   opcode;
        logic [IMM_W-1:0]  imm;
        logic [REG_AW-1:0] rs_addr;
        logic [REG_AW-1:0] rt_addr;
        logic [REG_AW-1:0] rd_addr;
        logic [DATA_W-1:0] rs_data;
        logic [DATA_W-1:0] rt_data;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
        logic              halt;
    } id_ex_t;

    // A later stage supplies a value only when it writes a real register
    // that matches the source; R0 is hard-wired and never forwarded.
    function automatic logic fwd_hit(input logic              wr_en,
                                     input logic [REG_AW-1:0] src_addr,
                                     input logic [REG_AW-1:0] dst_addr);
        return wr_en && (dst_addr != '0) && (dst_addr == src_addr);
    endfunction

endpackage
`default_nettype wire

// File: rtl/id_ex_pipe_if.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_pipe_if
// Description : ID-side, EX/MEM, MEM/WB and EX-side signals of the ID/EX stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface id_ex_pipe_if;
    import cpu_pkg::*;

    logic              stall;
    logic              flush;
    logic              id_valid;
    logic [OP_W-1:0]   id_opcode;
    logic [DATA_W-1:0] id_rs_data;
    logic [DATA_W-1:0] id_rt_data;
    logic [IMM_W-1:0]  id_imm;
    logic [REG_AW-1:0] id_rs_addr;
    logic [REG_AW-1:0] id_rt_addr;
    logic [REG_AW-1:0] id_rd_addr;
    logic              id_rs_used;
    logic              id_rt_used;
    logic              id_reg_write;
    logic              id_mem_read;
    logic              id_mem_write;
    logic              id_halt;
    logic [REG_AW-1:0] mem_rd_addr;
    logic              mem_reg_write;
    logic [DATA_W-1:0] mem_data;
    logic [REG_AW-1:0] wb_rd_addr;
    logic              wb_reg_write;
    logic [DATA_W-1:0] wb_data;
    logic              load_use_hold;
    logic              ex_valid;
    logic [OP_W-1:0]   ex_opcode;
    logic [IMM_W-1:0]  ex_imm;
    logic [REG_AW-1:0] ex_rd_addr;
    logic [DATA_W-1:0] ex_alu_a;
    logic [DATA_W-1:0] ex_alu_b;
    logic              ex_reg_write;
    logic              ex_mem_read;
    logic              ex_mem_write;
    logic              ex_halt;

    modport master (
        output stall, flush, id_valid, id_opcode, id_rs_data, id_rt_data, id_imm,
               id_rs_addr, id_rt_addr, id_rd_addr, id_rs_used, id_rt_used,
               id_reg_write, id_mem_read, id_mem_write, id_halt,
               mem_rd_addr, mem_reg_write, mem_data,
               wb_rd_addr, wb_reg_write, wb_data,
        input  load_use_hold, ex_valid, ex_opcode, ex_imm, ex_rd_addr,
               ex_alu_a, ex_alu_b, ex_reg_write, ex_mem_read, ex_mem_write, ex_halt
    );

    modport slave (
        input  stall, flush, id_valid, id_opcode, id_rs_data, id_rt_data, id_imm,
               id_rs_addr, id_rt_addr, id_rd_addr, id_rs_used, id_rt_used,
               id_reg_write, id_mem_read, id_mem_write, id_halt,
               mem_rd_addr, mem_reg_write, mem_data,
               wb_rd_addr, wb_reg_write, wb_data,
        output load_use_hold, ex_valid, ex_opcode, ex_imm, ex_rd_addr,
               ex_alu_a, ex_alu_b, ex_reg_write, ex_mem_read, ex_mem_write, ex_halt
    );

endinterface
`default_nettype wire

// File: rtl/fwd_mux.sv
`default_nettype none
// ============================================================================
// Module      : fwd_mux
// Description : Operand forwarding select; EX/MEM beats MEM/WB beats register.
// Revision    : 1.0 - initial release
// ============================================================================
module fwd_mux
    import cpu_pkg::*;
(
    input  wire logic [REG_AW-1:0] i_addr,
    input  wire logic [DATA_W-1:0] i_reg_data,
    input  wire logic [REG_AW-1:0] i_mem_rd_addr,
    input  wire logic              i_mem_reg_write,
    input  wire logic [DATA_W-1:0] i_mem_data,
    input  wire logic [REG_AW-1:0] i_wb_rd_addr,
    input  wire logic              i_wb_reg_write,
    input  wire logic [DATA_W-1:0] i_wb_data,
    output logic      [DATA_W-1:0] o_data
);

    always_comb begin
        o_data = i_reg_data;
        if (fwd_hit(i_mem_reg_write, i_addr, i_mem_rd_addr)) begin
            o_data = i_mem_data;
        end else if (fwd_hit(i_wb_reg_write, i_addr, i_wb_rd_addr)) begin
            o_data = i_wb_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/id_ex_pipe.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_pipe
// Description : ID/EX pipeline register with forwarding, load-use bubble
//               insertion and stall/flush handling.
// Revision    : 1.0 - initial release
// ============================================================================
module id_ex_pipe
    import cpu_pkg::*;
(
    input  wire logic     clk,
    input  wire logic     rst,
    id_ex_pipe_if.slave   bus
);

    id_ex_t r_stage;
    id_ex_t w_id_stage;
    logic   w_load_use_hold;
    logic   w_rs_dep;
    logic   w_rt_dep;

    always_comb begin
        w_id_stage           = '0;
        w_id_stage.valid     = bus.id_valid;
        w_id_stage.opcode    = bus.id_opcode;
        w_id_stage.imm       = bus.id_imm;
        w_id_stage.rs_addr   = bus.id_rs_addr;
        w_id_stage.rt_addr   = bus.id_rt_addr;
        w_id_stage.rd_addr   = bus.id_rd_addr;
        w_id_stage.rs_data   = bus.id_rs_data;
        w_id_stage.rt_data   = bus.id_rt_data;
        w_id_stage.reg_write = bus.id_reg_write;
        w_id_stage.mem_read  = bus.id_mem_read;
        w_id_stage.mem_write = bus.id_mem_write;
        w_id_stage.halt      = bus.id_halt;
    end

    // Load in EX whose result ID needs: the value only exists after MEM.
    assign w_rs_dep = bus.id_rs_used && (bus.id_rs_addr == r_stage.rd_addr);
    assign w_rt_dep = bus.id_rt_used && (bus.id_rt_addr == r_stage.rd_addr);
    assign w_load_use_hold = bus.id_valid && r_stage.valid && r_stage.mem_read
                             && (r_stage.rd_addr != '0) && (w_rs_dep || w_rt_dep);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stage <= '0;
        end else if (bus.stall) begin
            // Keep held operands current with values retiring during the stall.
            if (fwd_hit(bus.wb_reg_write, r_stage.rs_addr, bus.wb_rd_addr)) begin
                r_stage.rs_data <= bus.wb_data;
            end
            if (fwd_hit(bus.wb_reg_write, r_stage.rt_addr, bus.wb_rd_addr)) begin
                r_stage.rt_data <= bus.wb_data;
            end
        end else if (w_load_use_hold || bus.flush) begin
            r_stage <= '0;
        end else begin
            r_stage <= w_id_stage;
        end
    end

    fwd_mux u_fwd_rs (
        .i_addr          (r_stage.rs_addr),
        .i_reg_data      (r_stage.rs_data),
        .i_mem_rd_addr   (bus.mem_rd_addr),
        .i_mem_reg_write (bus.mem_reg_write),
        .i_mem_data      (bus.mem_data),
        .i_wb_rd_addr    (bus.wb_rd_addr),
        .i_wb_reg_write  (bus.wb_reg_write),
        .i_wb_data       (bus.wb_data),
        .o_data          (bus.ex_alu_a)
    );

    fwd_mux u_fwd_rt (
        .i_addr          (r_stage.rt_addr),
        .i_reg_data      (r_stage.rt_data),
        .i_mem_rd_addr   (bus.mem_rd_addr),
        .i_mem_reg_write (bus.mem_reg_write),
        .i_mem_data      (bus.mem_data),
        .i_wb_rd_addr    (bus.wb_rd_addr),
        .i_wb_reg_write  (bus.wb_reg_write),
        .i_wb_data       (bus.wb_data),
        .o_data          (bus.ex_alu_b)
    );

    assign bus.load_use_hold = w_load_use_hold;
    assign bus.ex_valid      = r_stage.valid;
    assign bus.ex_opcode     = r_stage.opcode;
    assign bus.ex_imm        = r_stage.imm;
    assign bus.ex_rd_addr    = r_stage.rd_addr;
    assign bus.ex_reg_write  = r_stage.reg_write && r_stage.valid;
    assign bus.ex_mem_read   = r_stage.mem_read  && r_stage.valid;
    assign bus.ex_mem_write  = r_stage.mem_write && r_stage.valid;
    assign bus.ex_halt       = r_stage.halt      && r_stage.valid;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_id_ex_pipe
// Description : Directed self-checking bench for the ID/EX pipeline stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_id_ex_pipe;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    id_ex_pipe_if bus ();

    id_ex_pipe u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_id(input logic v, input logic [3:0] opc,
                            input logic [3:0] rs, input logic [3:0] rt, input logic [3:0] rd,
                            input logic [15:0] rs_d, input logic [15:0] rt_d, input logic [7:0] imm,
                            input logic rs_u, input logic rt_u,
                            input logic rw, input logic mr, input logic mw, input logic ht);
        bus.id_valid     = v;
        bus.id_opcode    = opc;
        bus.id_rs_addr   = rs;
        bus.id_rt_addr   = rt;
        bus.id_rd_addr   = rd;
        bus.id_rs_data   = rs_d;
        bus.id_rt_data   = rt_d;
        bus.id_imm       = imm;
        bus.id_rs_used   = rs_u;
        bus.id_rt_used   = rt_u;
        bus.id_reg_write = rw;
        bus.id_mem_read  = mr;
        bus.id_mem_write = mw;
        bus.id_halt      = ht;
    endtask

    task automatic set_mem(input logic we, input logic [3:0] rd, input logic [15:0] d);
        bus.mem_reg_write = we;
        bus.mem_rd_addr   = rd;
        bus.mem_data      = d;
    endtask

    task automatic set_wb(input logic we, input logic [3:0] rd, input logic [15:0] d);
        bus.wb_reg_write = we;
        bus.wb_rd_addr   = rd;
        bus.wb_data      = d;
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        rst       = 1'b1;
        bus.stall = 1'b0;
        bus.flush = 1'b0;
        set_mem(1'b0, 4'd0, 16'h0000);
        set_wb(1'b0, 4'd0, 16'h0000);

        // Reset with a valid ADD presented by ID
        drive_id(1'b1, 4'b0000, 4'd1, 4'd2, 4'd3, 16'h1111, 16'h2222, 8'h12,
                 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        step();
        check("rst_valid",   {15'd0, bus.ex_valid}, 16'h0000);
        check("rst_opcode",  {12'd0, bus.ex_opcode}, 16'h0000);
        check("rst_imm",     {8'd0, bus.ex_imm}, 16'h0000);
        check("rst_rd",      {12'd0, bus.ex_rd_addr}, 16'h0000);
        check("rst_alu_a",   bus.ex_alu_a, 16'h0000);
        check("rst_alu_b",   bus.ex_alu_b, 16'h0000);
        check("rst_ctrl",    {12'd0, bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write, bus.ex_halt}, 16'h0000);
        check("rst_luh",     {15'd0, bus.load_use_hold}, 16'h0000);
        rst = 1'b0;
        bus.id_valid = 1'b0;
        step();
        check("post_rst_valid", {15'd0, bus.ex_valid}, 16'h0000);

        // EX/MEM forwarding and priority over MEM/WB
        drive_id(1'b1, 4'b0001, 4'd3, 4'd4, 4'd6, 16'h0003, 16'h0044, 8'h00,
                 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        bus.id_valid = 1'b0;
        set_mem(1'b1, 4'd3, 16'h1234);
        #1;
        check("fwd_mem_a",     bus.ex_alu_a, 16'h1234);
        check("fwd_none_b",    bus.ex_alu_b, 16'h0044);
        check("sub_opcode",    {12'd0, bus.ex_opcode}, 16'h0001);
        check("sub_rd",        {12'd0, bus.ex_rd_addr}, 16'h0006);
        check("sub_reg_write", {15'd0, bus.ex_reg_write}, 16'h0001);
        set_wb(1'b1, 4'd3, 16'h5555);
        #1;
        check("fwd_mem_prio", bus.ex_alu_a, 16'h1234);
        set_mem(1'b0, 4'd3, 16'h1234);
        #1;
        check("fwd_wb_a", bus.ex_alu_a, 16'h5555);
        set_wb(1'b1, 4'd4, 16'h4444);
        #1;
        check("fwd_wb_b", bus.ex_alu_b, 16'h4444);
        check("wb_no_a",  bus.ex_alu_a, 16'h0003);
        set_wb(1'b0, 4'd0, 16'h0000);

        // R0 is never forwarded
        drive_id(1'b1, 4'b0000, 4'd0, 4'd0, 4'd1, 16'h0000, 16'h0000, 8'h00,
                 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        set_mem(1'b1, 4'd0, 16'hFFFF);
        set_wb(1'b1, 4'd0, 16'h7777);
        #1;
        check("r0_guard_a", bus.ex_alu_a, 16'h0000);
        check("r0_guard_b", bus.ex_alu_b, 16'h0000);
        set_mem(1'b0, 4'd0, 16'h0000);
        set_wb(1'b0, 4'd0, 16'h0000);

        // Load-use: LW R5 in EX, ADD reading R5 in ID
        drive_id(1'b1, 4'b1000, 4'd1, 4'd0, 4'd5, 16'h0010, 16'h0000, 8'h04,
                 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        drive_id(1'b1, 4'b0000, 4'd5, 4'd2, 4'd6, 16'h0000, 16'h0002, 8'h00,
                 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        check("lw_mem_read", {15'd0, bus.ex_mem_read}, 16'h0001);
        check("lw_imm",      {8'd0, bus.ex_imm}, 16'h0004);
        check("luh_set",     {15'd0, bus.load_use_hold}, 16'h0001);
        bus.id_valid = 1'b0;
        #1;
        check("luh_id_invalid", {15'd0, bus.load_use_hold}, 16'h0000);
        bus.id_valid   = 1'b1;
        bus.id_rs_used = 1'b0;
        #1;
        check("luh_rs_unused", {15'd0, bus.load_use_hold}, 16'h0000);
        bus.id_rs_used = 1'b1;
        step();
        check("luh_bubble_valid", {15'd0, bus.ex_valid}, 16'h0000);
        check("luh_bubble_rw",    {15'd0, bus.ex_reg_write}, 16'h0000);
        check("luh_cleared",      {15'd0, bus.load_use_hold}, 16'h0000);
        step();
        set_wb(1'b1, 4'd5, 16'h00AB);
        #1;
        check("lu_valid",  {15'd0, bus.ex_valid}, 16'h0001);
        check("lu_fwd_wb", bus.ex_alu_a, 16'h00AB);
        check("lu_alu_b",  bus.ex_alu_b, 16'h0002);
        set_wb(1'b0, 4'd0, 16'h0000);

        // Stall with a write-back refreshing held rt data
        drive_id(1'b1, 4'b0010, 4'd1, 4'd7, 4'd2, 16'h0101, 16'h0707, 8'h00,
                 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        bus.stall = 1'b1;
        drive_id(1'b1, 4'b0000, 4'd8, 4'd9, 4'd10, 16'h0808, 16'h0909, 8'h00,
                 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        check("stall_hold_op", {12'd0, bus.ex_opcode}, 16'h0002);
        set_wb(1'b1, 4'd7, 16'hBEEF);
        step();
        set_wb(1'b0, 4'd0, 16'h0000);
        step();
        bus.stall = 1'b0;
        #1;
        check("stall_refresh_b", bus.ex_alu_b, 16'hBEEF);
        check("stall_keep_a",    bus.ex_alu_a, 16'h0101);
        check("stall_keep_rd",   {12'd0, bus.ex_rd_addr}, 16'h0002);
        check("stall_valid",     {15'd0, bus.ex_valid}, 16'h0001);

        // Flush of a SW, first blocked by stall
        drive_id(1'b1, 4'b1001, 4'd1, 4'd2, 4'd0, 16'h0001, 16'h0002, 8'h03,
                 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        bus.flush = 1'b1;
        bus.stall = 1'b1;
        step();
        check("flush_stall_op", {12'd0, bus.ex_opcode}, 16'h0002);
        check("flush_stall_b",  bus.ex_alu_b, 16'hBEEF);
        bus.stall = 1'b0;
        step();
        check("flush_valid", {15'd0, bus.ex_valid}, 16'h0000);
        check("flush_mw",    {15'd0, bus.ex_mem_write}, 16'h0000);
        bus.flush = 1'b0;
        step();
        check("sw_valid", {15'd0, bus.ex_valid}, 16'h0001);
        check("sw_mw",    {15'd0, bus.ex_mem_write}, 16'h0001);
        check("sw_op",    {12'd0, bus.ex_opcode}, 16'h0009);

        // Flush coinciding with load-use costs one bubble only
        drive_id(1'b1, 4'b1000, 4'd1, 4'd0, 4'd5, 16'h0010, 16'h0000, 8'h00,
                 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        drive_id(1'b1, 4'b0000, 4'd5, 4'd2, 4'd6, 16'h0000, 16'h0002, 8'h00,
                 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        bus.flush = 1'b1;
        #1;
        check("fl_luh_set", {15'd0, bus.load_use_hold}, 16'h0001);
        step();
        check("fl_luh_bubble", {15'd0, bus.ex_valid}, 16'h0000);
        bus.flush = 1'b0;
        #1;
        check("fl_luh_clear", {15'd0, bus.load_use_hold}, 16'h0000);
        step();
        check("fl_luh_next_valid", {15'd0, bus.ex_valid}, 16'h0001);
        check("fl_luh_next_rw",    {15'd0, bus.ex_reg_write}, 16'h0001);

        // HLT control bit, then reset during stall
        drive_id(1'b1, 4'b1111, 4'd0, 4'd0, 4'd0, 16'h0000, 16'h0000, 8'h00,
                 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step();
        check("hlt_halt", {15'd0, bus.ex_halt}, 16'h0001);
        bus.stall = 1'b1;
        rst       = 1'b1;
        step();
        check("rst_stall_valid", {15'd0, bus.ex_valid}, 16'h0000);
        check("rst_stall_halt",  {15'd0, bus.ex_halt}, 16'h0000);
        check("rst_stall_op",    {12'd0, bus.ex_opcode}, 16'h0000);
        rst       = 1'b0;
        bus.stall = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/id_ex_pipe.md
# id_ex_pipe

ID/EX pipeline stage of the 16-bit processor: registers decoded operands and control from the decode stage and presents forwarded operands, immediate and opcode to the ALU in EX. It also owns operand forwarding from the EX/MEM and MEM/WB stages, load-use hazard detection and bubble insertion, and stall/flush handling. Every operand the ALU sees passes through this block.

## Interface
- No parameters. Data width is 16, register address width is 4 and opcode width is 4, all fixed by the ISA.
- clk  in  1  sole clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- stall  in  1  global pipeline hold (memory wait); freezes stage contents
- flush  in  1  squash the instruction entering from ID (branch taken in ID)
- id_valid  in  1  ID holds a real instruction
- id_opcode  in  4  opcode
- id_rs_data, id_rt_data  in  16  register-file read data
- id_imm  in  8  raw immediate field
- id_rs_addr, id_rt_addr, id_rd_addr  in  4  source/destination register numbers
- id_rs_used, id_rt_used  in  1  instruction actually reads rs / rt
- id_reg_write, id_mem_read, id_mem_write, id_halt  in  1  control bits
- mem_rd_addr  in  4 ; mem_reg_write  in  1 ; mem_data  in  16  EX/MEM result
- wb_rd_addr  in  4 ; wb_reg_write  in  1 ; wb_data  in  16  MEM/WB write-back
- load_use_hold  out  1  combinational; PC and IF/ID must hold this cycle
- ex_valid  out  1  EX holds a real instruction
- ex_opcode  out  4 ; ex_imm  out  8 ; ex_rd_addr  out  4
- ex_alu_a  out  16  forwarded rs operand
- ex_alu_b  out  16  forwarded rt operand; also the store data
- ex_reg_write, ex_mem_read, ex_mem_write, ex_halt  out  1  gated with ex_valid

## Operation
- Registered fields: valid, opcode, imm, rs/rt/rd addr, rs/rt data, four control bits.
- Per-edge update priority: rst > stall > load_use_hold > flush > normal load.
  - rst: all registered fields cleared to 0, giving a bubble.
  - stall: all fields held. While held, any wb_reg_write to a nonzero wb_rd_addr matching the held rs_addr (resp. rt_addr) overwrites the held rs data (resp. rt data) with wb_data, so a long stall cannot lose a retiring value.
  - load_use_hold: load a bubble (valid=0, control bits 0); ID is held upstream.
  - flush: load a bubble.
  - Otherwise: capture ID fields; valid = id_valid.
- load_use_hold = ex_valid & ex_mem_read & ex_rd_addr≠0 & ((id_rs_used & id_rs_addr==ex_rd_addr) | (id_rt_used & id_rt_addr==ex_rd_addr)). It is forced to 0 when id_valid=0 and is computed irrespective of stall.
- Forwarding is combinational from the registered addresses, separately for rs→ex_alu_a and rt→ex_alu_b:
  - If the address is 0, output the registered data; R0 is never forwarded.
  - Else if mem_reg_write and mem_rd_addr matches, output mem_data. EX/MEM has priority.
  - Else if wb_reg_write and wb_rd_addr matches, output wb_data.
  - Else output the registered data.
- Control outputs are ANDed with ex_valid; data outputs are not gated.
- The register file is assumed write-before-read; same-cycle WB→ID bypass is not this block's job.

## Timing
- Latency is 1 cycle from ID inputs to ex_* outputs. Forwarding muxes add combinational delay only.
- After reset, every output is 0 (ex_alu_a/b = 0 because the addresses are 0) until the first load.
- A load-use dependency costs exactly one bubble cycle. The next edge (no stall) loads the dependent instruction, and by then the load has reached MEM/WB and is forwarded from WB.
- Back-to-back ALU dependencies need 0 bubbles, served from EX/MEM.
- flush and load_use_hold in the same cycle produce one bubble, not two.
- rst asserted mid-stall clears the stage on that edge; stall is ignored during rst.

## Structure
- Shared cpu_pkg: opcode localparams (ADD 0000, SUB 0001, XOR 0010, RED 0011, SLL 0100, SRA 0101, ROR 0110, PADDSB 0111, LW 1000, SW 1001, LLB 1010, LHB 1011, B 1100, BR 1101, PCS 1110, HLT 1111), plus DATA_W=16 and REG_AW=4.
- One sub-module, fwd_mux, instantiated twice (rs and rt). Inputs: address, registered data, MEM and WB ports. Output: the forwarded word.

## Test plan
- Reset: assert rst for 2 cycles with ID driving a valid ADD. All outputs read 0 and ex_valid=0 on the first edge after release.
- EX/MEM forward: ADD R3 in MEM (mem_data=16'h1234) while EX holds SUB with rs=R3 → ex_alu_a=16'h1234. With mem and wb both targeting R3 (wb_data=16'h5555), the result is still 16'h1234.
- R0 guard: mem_rd_addr=0, mem_reg_write=1, mem_data=16'hFFFF, EX rs=R0 with registered data 0 → ex_alu_a=0.
- Load-use: LW R5 in EX, ID ADD with rs=R5 used → load_use_hold=1 for one cycle and a bubble enters EX. On the next edge the ADD loads, and wb_data=16'h00AB from R5 gives ex_alu_a=16'h00AB.
- Stall refresh: stall=1 for 3 cycles with EX rt=R7 held; in cycle 2, wb writes R7=16'hBEEF; after release with no forward, ex_alu_b=16'hBEEF.
- Flush: flush=1 with a valid SW in ID → ex_valid=0 and ex_mem_write=0 next cycle. With stall=1 also asserted, the old EX contents are held unchanged.
